// File: rtl/control_sequencer_pkg.sv
// Shared definitions for the hardwired control sequencer.
// Holds opcode encodings, ALU function encodings, FSM state and opcode-class
// enums, the packed control-strobe bundle, and the per-state strobe decode.
package control_sequencer_pkg;

    localparam int CS_OPW  = 5;
    localparam int CS_ALUW = 4;

    localparam logic [CS_OPW-1:0] OP_ADD  = 5'b00011;
    localparam logic [CS_OPW-1:0] OP_SUB  = 5'b00100;
    localparam logic [CS_OPW-1:0] OP_AND  = 5'b00101;
    localparam logic [CS_OPW-1:0] OP_OR   = 5'b00110;
    localparam logic [CS_OPW-1:0] OP_NEG  = 5'b10001;
    localparam logic [CS_OPW-1:0] OP_NOT  = 5'b10010;
    localparam logic [CS_OPW-1:0] OP_NOP  = 5'b11010;
    localparam logic [CS_OPW-1:0] OP_HALT = 5'b11011;

    typedef enum logic [CS_ALUW-1:0] {
        ALU_NONE = 4'd0,
        ALU_ADD  = 4'd1,
        ALU_SUB  = 4'd2,
        ALU_AND  = 4'd3,
        ALU_OR   = 4'd4,
        ALU_NEG  = 4'd5,
        ALU_NOT  = 4'd6
    } alu_op_t;

    typedef enum logic [2:0] {
        RST_S, T0, T1, T2, T3, T4, T5, HALT_S
    } state_t;

    typedef enum logic [2:0] {
        CLS_BIN, CLS_UN, CLS_NOP, CLS_HALT, CLS_ILL
    } op_class_t;

    typedef struct packed {
        logic    run;
        logic    illegal;
        alu_op_t alu_op;
        logic    PCout;
        logic    Zlowout;
        logic    MDRout;
        logic    Rout;
        logic    MARin;
        logic    PCin;
        logic    MDRin;
        logic    IRin;
        logic    Yin;
        logic    Zlowin;
        logic    Rin;
        logic    IncPC;
        logic    Read;
        logic    Gra;
        logic    Grb;
        logic    Grc;
    } ctrl_t;

    // Strobes for the cycle spent in state st. first_t1 is set when st is T1
    // and the previous state was not T1, so PCin fires once per fetch even
    // when T1 stretches for memory.
    function automatic ctrl_t ctrl_decode(input state_t    st,
                                          input op_class_t cls,
                                          input alu_op_t   op,
                                          input logic      first_t1);
        ctrl_t c;
        c        = '0;
        c.alu_op = ALU_NONE;
        c.run    = (st != RST_S) && (st != HALT_S);
        case (st)
            T0: begin
                c.PCout  = 1'b1;
                c.MARin  = 1'b1;
                c.IncPC  = 1'b1;
                c.Zlowin = 1'b1;
            end
            T1: begin
                c.Zlowout = 1'b1;
                c.PCin    = first_t1;
                c.Read    = 1'b1;
                c.MDRin   = 1'b1;
            end
            T2: begin
                c.MDRout = 1'b1;
                c.IRin   = 1'b1;
            end
            T3: begin
                case (cls)
                    CLS_BIN: begin
                        c.Grb  = 1'b1;
                        c.Rout = 1'b1;
                        c.Yin  = 1'b1;
                    end
                    CLS_UN: begin
                        c.Grb    = 1'b1;
                        c.Rout   = 1'b1;
                        c.alu_op = op;
                        c.Zlowin = 1'b1;
                    end
                    CLS_ILL: c.illegal = 1'b1;
                    default: ;
                endcase
            end
            T4: begin
                case (cls)
                    CLS_BIN: begin
                        c.Grc    = 1'b1;
                        c.Rout   = 1'b1;
                        c.alu_op = op;
                        c.Zlowin = 1'b1;
                    end
                    CLS_UN: begin
                        c.Zlowout = 1'b1;
                        c.Gra     = 1'b1;
                        c.Rin     = 1'b1;
                    end
                    default: ;
                endcase
            end
            T5: begin
                c.Zlowout = 1'b1;
                c.Gra     = 1'b1;
                c.Rin     = 1'b1;
            end
            default: ;
        endcase
        return c;
    endfunction

endpackage

// File: rtl/control_sequencer_if.sv
// Bundle between the control sequencer and the datapath.
//   IR, mem_ready, stop        : datapath -> sequencer
//   bus drivers, load enables,
//   register-file selects,
//   alu_op, run, illegal       : sequencer -> datapath
// master modport is the sequencer side, slave modport the datapath side.
interface control_sequencer_if #(
    parameter int IRW  = 32,
    parameter int ALUW = 4
);
    logic [IRW-1:0]  IR;
    logic            mem_ready;
    logic            stop;
    logic            PCout, Zlowout, MDRout;
    logic            MARin, PCin, MDRin, IRin, Yin, Zlowin;
    logic            IncPC, Read;
    logic            Gra, Grb, Grc;
    logic            Rin, Rout;
    logic [ALUW-1:0] alu_op;
    logic            run;
    logic            illegal;

    modport master (
        input  IR, mem_ready, stop,
        output PCout, Zlowout, MDRout,
        output MARin, PCin, MDRin, IRin, Yin, Zlowin,
        output IncPC, Read, Gra, Grb, Grc, Rin, Rout,
        output alu_op, run, illegal
    );

    modport slave (
        output IR, mem_ready, stop,
        input  PCout, Zlowout, MDRout,
        input  MARin, PCin, MDRin, IRin, Yin, Zlowin,
        input  IncPC, Read, Gra, Grb, Grc, Rin, Rout,
        input  alu_op, run, illegal
    );
endinterface

// File: rtl/control_sequencer_decoder.sv
// Combinational opcode decoder.
//   op_i     : opcode field IR[31:27]
//   cls_o    : instruction class (binary, unary, nop, halt, illegal)
//   alu_op_o : ALU function for binary/unary ops, ALU_NONE otherwise
module control_sequencer_decoder
    import control_sequencer_pkg::*;
#(
    parameter int OPW = CS_OPW
) (
    input  logic [OPW-1:0] op_i,
    output op_class_t      cls_o,
    output alu_op_t        alu_op_o
);
    always_comb begin
        cls_o    = CLS_ILL;
        alu_op_o = ALU_NONE;
        case (op_i)
            OP_ADD:  begin cls_o = CLS_BIN; alu_op_o = ALU_ADD; end
            OP_SUB:  begin cls_o = CLS_BIN; alu_op_o = ALU_SUB; end
            OP_AND:  begin cls_o = CLS_BIN; alu_op_o = ALU_AND; end
            OP_OR:   begin cls_o = CLS_BIN; alu_op_o = ALU_OR;  end
            OP_NEG:  begin cls_o = CLS_UN;  alu_op_o = ALU_NEG; end
            OP_NOT:  begin cls_o = CLS_UN;  alu_op_o = ALU_NOT; end
            OP_NOP:  cls_o = CLS_NOP;
            OP_HALT: cls_o = CLS_HALT;
            default: ;
        endcase
    end
endmodule

// File: rtl/control_sequencer.sv
// Hardwired control unit: Moore FSM stepping T0..T5 per instruction.
//   clock : system clock, rising edge
//   clear : synchronous active-high reset, aborts any instruction in flight
//   bus   : control_sequencer_if.master (IR, mem_ready, stop in; all
//           datapath strobes, alu_op, run, illegal out)
// All outputs come straight from a register; nothing from the inputs reaches
// an output without passing a clock edge.
module control_sequencer
    import control_sequencer_pkg::*;
#(
    parameter int IRW  = 32,
    parameter int OPW  = CS_OPW,
    parameter int ALUW = CS_ALUW
) (
    input  logic                clock,
    input  logic                clear,
    control_sequencer_if.master bus
);
    state_t         state_q, state_d;
    logic [OPW-1:0] op_q;
    logic [OPW-1:0] op_sel;
    op_class_t      cls_cur;
    alu_op_t        alu_cur;
    ctrl_t          ctrl_q;

    // While in T2 the opcode is about to be latched, so decode IR directly;
    // that lets the T3 strobes be registered on the same edge op_q loads.
    assign op_sel = (state_q == T2) ? bus.IR[IRW-1 -: OPW] : op_q;

    control_sequencer_decoder #(.OPW(OPW)) u_dec (
        .op_i     (op_sel),
        .cls_o    (cls_cur),
        .alu_op_o (alu_cur)
    );

    always_comb begin
        state_d = state_q;
        case (state_q)
            RST_S: state_d = T0;
            T0:    state_d = T1;
            T1:    if (bus.mem_ready) state_d = T2;
            T2:    state_d = T3;
            T3: begin
                case (cls_cur)
                    CLS_BIN, CLS_UN: state_d = T4;
                    CLS_HALT:        state_d = HALT_S;
                    default:         state_d = bus.stop ? HALT_S : T0;
                endcase
            end
            T4: begin
                if (cls_cur == CLS_UN) state_d = bus.stop ? HALT_S : T0;
                else                   state_d = T5;
            end
            T5:     state_d = bus.stop ? HALT_S : T0;
            HALT_S: state_d = HALT_S;
            default: state_d = RST_S;
        endcase
    end

    always_ff @(posedge clock) begin
        if (clear) begin
            state_q <= RST_S;
            op_q    <= '0;
            ctrl_q  <= '0;
        end else begin
            state_q <= state_d;
            if (state_q == T2) op_q <= bus.IR[IRW-1 -: OPW];
            ctrl_q  <= ctrl_decode(state_d, cls_cur, alu_cur, state_q != T1);
        end
    end

    assign bus.run     = ctrl_q.run;
    assign bus.illegal = ctrl_q.illegal;
    assign bus.alu_op  = ALUW'(ctrl_q.alu_op);
    assign bus.PCout   = ctrl_q.PCout;
    assign bus.Zlowout = ctrl_q.Zlowout;
    assign bus.MDRout  = ctrl_q.MDRout;
    assign bus.Rout    = ctrl_q.Rout;
    assign bus.MARin   = ctrl_q.MARin;
    assign bus.PCin    = ctrl_q.PCin;
    assign bus.MDRin   = ctrl_q.MDRin;
    assign bus.IRin    = ctrl_q.IRin;
    assign bus.Yin     = ctrl_q.Yin;
    assign bus.Zlowin  = ctrl_q.Zlowin;
    assign bus.Rin     = ctrl_q.Rin;
    assign bus.IncPC   = ctrl_q.IncPC;
    assign bus.Read    = ctrl_q.Read;
    assign bus.Gra     = ctrl_q.Gra;
    assign bus.Grb     = ctrl_q.Grb;
    assign bus.Grc     = ctrl_q.Grc;
endmodule

// File: tb/tb_control_sequencer.sv
// Directed bench for control_sequencer. Each stimulus step pushes the strobe
// vector expected after the next rising edge; a monitor pops and compares.
module tb_control_sequencer;
    logic clk;
    logic clear;

    control_sequencer_if #(.IRW(32), .ALUW(4)) bus ();

    control_sequencer #(.IRW(32), .OPW(5), .ALUW(4)) dut (
        .clock (clk),
        .clear (clear),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // {run, illegal, alu_op[3:0], PCout, Zlowout, MDRout, Rout, MARin, PCin,
    //  MDRin, IRin, Yin, Zlowin, Rin, IncPC, Read, Gra, Grb, Grc}
    localparam logic [21:0] RUN     = 22'h200000;
    localparam logic [21:0] ILLEGAL = 22'h100000;
    localparam logic [21:0] PCOUT   = 22'h008000;
    localparam logic [21:0] ZLOWOUT = 22'h004000;
    localparam logic [21:0] MDROUT  = 22'h002000;
    localparam logic [21:0] ROUT    = 22'h001000;
    localparam logic [21:0] MARIN   = 22'h000800;
    localparam logic [21:0] PCIN    = 22'h000400;
    localparam logic [21:0] MDRIN   = 22'h000200;
    localparam logic [21:0] IRIN    = 22'h000100;
    localparam logic [21:0] YIN     = 22'h000080;
    localparam logic [21:0] ZLOWIN  = 22'h000040;
    localparam logic [21:0] RIN     = 22'h000020;
    localparam logic [21:0] INCPC   = 22'h000010;
    localparam logic [21:0] READ    = 22'h000008;
    localparam logic [21:0] GRA     = 22'h000004;
    localparam logic [21:0] GRB     = 22'h000002;
    localparam logic [21:0] GRC     = 22'h000001;

    localparam logic [21:0] E_OFF = 22'h0;
    localparam logic [21:0] E_T0  = RUN | PCOUT | MARIN | INCPC | ZLOWIN;
    localparam logic [21:0] E_T1F = RUN | ZLOWOUT | PCIN | READ | MDRIN;
    localparam logic [21:0] E_T1W = RUN | ZLOWOUT | READ | MDRIN;
    localparam logic [21:0] E_T2  = RUN | MDROUT | IRIN;
    localparam logic [21:0] E_B3  = RUN | GRB | ROUT | YIN;
    localparam logic [21:0] E_B4  = RUN | GRC | ROUT | ZLOWIN;
    localparam logic [21:0] E_U3  = RUN | GRB | ROUT | ZLOWIN;
    localparam logic [21:0] E_WB  = RUN | ZLOWOUT | GRA | RIN;

    localparam logic [31:0] I_ADD  = 32'h18918000;
    localparam logic [31:0] I_SUB  = 32'h20000000;
    localparam logic [31:0] I_AND  = 32'h28000000;
    localparam logic [31:0] I_NEG  = 32'h88900000;
    localparam logic [31:0] I_NOT  = 32'h90000000;
    localparam logic [31:0] I_NOP  = 32'hD0000000;
    localparam logic [31:0] I_HALT = 32'hD8000000;
    localparam logic [31:0] I_ILL  = 32'hF8000000;

    function automatic logic [21:0] alu(input logic [3:0] n);
        return {2'b00, n, 16'h0000};
    endfunction

    logic [21:0] exp_q[$];
    string       name_q[$];
    int          total = 0;
    int          bad   = 0;

    task automatic step(input logic c, input logic mr, input logic stp,
                        input logic [31:0] ir, input logic [21:0] e,
                        input string nm);
        @(negedge clk);
        clear         = c;
        bus.mem_ready = mr;
        bus.stop      = stp;
        bus.IR        = ir;
        exp_q.push_back(e);
        name_q.push_back(nm);
    endtask

    // From T0: enter T1 with memory ready, then T2.
    task automatic fetch(input logic [31:0] ir, input string nm);
        step(1'b0, 1'b1, 1'b0, ir, E_T1F, {nm, "_t1"});
        step(1'b0, 1'b1, 1'b0, ir, E_T2,  {nm, "_t2"});
    endtask

    // Monitor / scoreboard
    initial begin
        logic [21:0] act;
        logic [21:0] e;
        string       nm;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() != 0) begin
                e  = exp_q.pop_front();
                nm = name_q.pop_front();
                act = {bus.run, bus.illegal, bus.alu_op,
                       bus.PCout, bus.Zlowout, bus.MDRout, bus.Rout,
                       bus.MARin, bus.PCin, bus.MDRin, bus.IRin, bus.Yin,
                       bus.Zlowin, bus.Rin, bus.IncPC, bus.Read,
                       bus.Gra, bus.Grb, bus.Grc};
                total++;
                if (act !== e) begin
                    bad++;
                    $display("FAIL %s: got %06h expected %06h", nm, act, e);
                end
            end
        end
    end

    initial begin
        clear         = 1'b1;
        bus.mem_ready = 1'b0;
        bus.stop      = 1'b0;
        bus.IR        = '0;

        // reset with IR unknown
        step(1'b1, 1'b1, 1'b0, 'x, E_OFF, "rst0");
        step(1'b1, 1'b1, 1'b0, 'x, E_OFF, "rst1");
        step(1'b1, 1'b1, 1'b0, 'x, E_OFF, "rst2");
        step(1'b0, 1'b1, 1'b0, I_ADD, E_T0, "t0_after_rst");

        // ADD with two memory wait cycles in T1
        step(1'b0, 1'b0, 1'b0, I_ADD, E_T1F, "add_t1_first");
        step(1'b0, 1'b0, 1'b0, I_ADD, E_T1W, "add_t1_wait1");
        step(1'b0, 1'b0, 1'b0, I_ADD, E_T1W, "add_t1_wait2");
        step(1'b0, 1'b1, 1'b0, I_ADD, E_T2,  "add_t2");
        step(1'b0, 1'b1, 1'b0, I_ADD, E_B3,  "add_t3");
        step(1'b0, 1'b1, 1'b0, I_ADD, E_B4 | alu(4'd1), "add_t4");
        step(1'b0, 1'b1, 1'b0, I_ADD, E_WB,  "add_t5");
        step(1'b0, 1'b1, 1'b0, I_ADD, E_T0,  "add_t0");

        // NEG; IR changes after T3 entry must not affect execution
        fetch(I_NEG, "neg");
        step(1'b0, 1'b1, 1'b0, I_NEG, E_U3 | alu(4'd5), "neg_t3");
        step(1'b0, 1'b1, 1'b0, I_ILL, E_WB, "neg_t4");
        step(1'b0, 1'b1, 1'b0, I_ILL, E_T0, "neg_t0");

        // illegal opcode
        fetch(I_ILL, "ill");
        step(1'b0, 1'b1, 1'b0, I_ILL, RUN | ILLEGAL, "ill_t3");
        step(1'b0, 1'b1, 1'b0, I_ILL, E_T0, "ill_t0");

        // NOP
        fetch(I_NOP, "nop");
        step(1'b0, 1'b1, 1'b0, I_NOP, RUN,  "nop_t3");
        step(1'b0, 1'b1, 1'b0, I_NOP, E_T0, "nop_t0");

        // AND and NOT alu_op encodings
        fetch(I_AND, "and");
        step(1'b0, 1'b1, 1'b0, I_AND, E_B3, "and_t3");
        step(1'b0, 1'b1, 1'b0, I_AND, E_B4 | alu(4'd3), "and_t4");
        step(1'b0, 1'b1, 1'b0, I_AND, E_WB, "and_t5");
        step(1'b0, 1'b1, 1'b0, I_AND, E_T0, "and_t0");
        fetch(I_NOT, "not");
        step(1'b0, 1'b1, 1'b0, I_NOT, E_U3 | alu(4'd6), "not_t3");
        step(1'b0, 1'b1, 1'b0, I_NOT, E_WB, "not_t4");
        step(1'b0, 1'b1, 1'b0, I_NOT, E_T0, "not_t0");

        // SUB with stop: ignored at end of T4, honoured at end of T5
        fetch(I_SUB, "sub");
        step(1'b0, 1'b1, 1'b0, I_SUB, E_B3, "sub_t3");
        step(1'b0, 1'b1, 1'b0, I_SUB, E_B4 | alu(4'd2), "sub_t4");
        step(1'b0, 1'b1, 1'b1, I_SUB, E_WB, "sub_t5_stop_early");
        step(1'b0, 1'b1, 1'b1, I_SUB, E_OFF, "stop_halt");
        step(1'b0, 1'b1, 1'b0, I_SUB, E_OFF, "stop_halt_hold");
        step(1'b1, 1'b1, 1'b0, I_SUB, E_OFF, "stop_clear");
        step(1'b0, 1'b1, 1'b0, I_ADD, E_T0,  "stop_restart");

        // clear during T4 of ADD aborts before any write-back
        fetch(I_ADD, "abort");
        step(1'b0, 1'b1, 1'b0, I_ADD, E_B3, "abort_t3");
        step(1'b0, 1'b1, 1'b0, I_ADD, E_B4 | alu(4'd1), "abort_t4");
        step(1'b1, 1'b1, 1'b0, I_ADD, E_OFF, "abort_rst");
        step(1'b0, 1'b1, 1'b0, I_ADD, E_T0,  "abort_t0");

        // HALT opcode: halts and stays halted
        fetch(I_HALT, "halt");
        step(1'b0, 1'b1, 1'b0, I_HALT, RUN,   "halt_t3");
        step(1'b0, 1'b1, 1'b0, I_HALT, E_OFF, "halt_s");
        step(1'b0, 1'b0, 1'b1, I_ADD,  E_OFF, "halt_hold1");
        step(1'b0, 1'b1, 1'b0, I_ADD,  E_OFF, "halt_hold2");

        for (int i = 0; i < 20 && exp_q.size() != 0; i++) begin
            @(posedge clk);
            #2;
        end
        if (exp_q.size() != 0) begin
            total++;
            bad++;
            $display("FAIL drain: %0d pending, expected 0", exp_q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
